// File: rtl/seg7_cap_pkg.sv
// Shared types and constants for the seven-segment scan capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Segment patterns use 1 = lit, bit 0 = segment a ... bit 6 = segment g.
package seg7_cap_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Frame hand-off state.
  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } frame_state_e;

  // One captured digit position.
  typedef struct packed {
    logic [3:0] code;
    logic       blank;
    logic       bad;
    logic       dp;
  } slot_t;

  // Normalised bus sample (1 = lit / enabled).
  typedef struct packed {
    logic [3:0] act;
    logic       pt;
    logic [6:0] seg;
  } samp_t;

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment pattern to hex code decoder, flags blank and undecodable.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   i_seg   - segment pattern, 1 = lit, bit 0 = segment a
//   o_code  - hex value shown (0 when blank or bad)
//   o_blank - all segments off
//   o_bad   - pattern is not one of the 16 hex glyphs
module seg7_decode
  import seg7_cap_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_blank,
  output logic       o_bad
);

  always_comb begin
    o_code  = 4'h0;
    o_blank = 1'b0;
    o_bad   = 1'b0;
    case (i_seg)
      SEG_0:   o_code = 4'h0;
      SEG_1:   o_code = 4'h1;
      SEG_2:   o_code = 4'h2;
      SEG_3:   o_code = 4'h3;
      SEG_4:   o_code = 4'h4;
      SEG_5:   o_code = 4'h5;
      SEG_6:   o_code = 4'h6;
      SEG_7:   o_code = 4'h7;
      SEG_8:   o_code = 4'h8;
      SEG_9:   o_code = 4'h9;
      SEG_A:   o_code = 4'hA;
      SEG_B:   o_code = 4'hB;
      SEG_C:   o_code = 4'hC;
      SEG_D:   o_code = 4'hD;
      SEG_E:   o_code = 4'hE;
      SEG_F:   o_code = 4'hF;
      SEG_OFF: o_blank = 1'b1;
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Rebuilds four multiplexed seven-segment digits into a parallel frame.
// Latency: digit captured SETTLE edges after its first sample; frame valid one edge later.
// Backpressure: unaccepted frame is replaced by the next one, flagged with an overrun pulse.
//
// Ports:
//   clk, rst         - clock, synchronous active-low reset
//   LEDs/active/point - scanned display bus (polarity set by ACTIVE_LOW)
//   frame_ready      - consumer accepts the presented frame
//   frame_valid      - frame held on digits/blank/bad/dp
//   digits           - digits[4i+3:4i] is the hex code of digit i
//   blank/bad/dp     - per-digit off / undecodable / decimal point flags
//   err              - one-cycle pulse on a settled multi-hot enable
//   overrun          - one-cycle pulse when a presented frame is replaced
//   stale            - no frame completed in the last TIMEOUT cycles
module seg7_scan_capture
  import seg7_cap_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  LEDs,
  input  logic [3:0]  active,
  input  logic        point,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic [3:0]  dp,
  output logic        err,
  output logic        overrun,
  output logic        stale
);

  localparam logic [3:0] SETTLE_N  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam int         AGE_W     = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Input stage: normalise to 1 = lit/enabled and register every cycle.
  // ---------------------------------------------------------------------------
  samp_t w_raw;
  samp_t w_norm;
  samp_t r_samp;

  assign w_raw  = {active, point, LEDs};
  assign w_norm = ACTIVE_LOW ? ~w_raw : w_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_samp <= '0;
    end else begin
      r_samp <= w_norm;
    end
  end

  // ---------------------------------------------------------------------------
  // Dwell tracking. w_same means the sample register will not change at this
  // edge, so the count advances; the settle hit is the edge on which the count
  // reaches SETTLE, which happens exactly once per dwell thanks to saturation.
  // ---------------------------------------------------------------------------
  logic [3:0] r_cnt;
  logic       w_same;
  logic       w_settle_hit;
  logic       w_onehot;
  logic       w_multi;
  logic       w_strobe;

  assign w_same       = (w_norm == r_samp);
  assign w_settle_hit = w_same && (r_cnt == SETTLE_M1);
  assign w_multi      = ((r_samp.act & (r_samp.act - 4'd1)) != 4'd0);
  assign w_onehot     = (r_samp.act != 4'd0) && !w_multi;
  assign w_strobe     = w_settle_hit && w_onehot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_same) begin
      r_cnt <= '0;
    end else if (r_cnt != SETTLE_N) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode the settled segment field.
  // ---------------------------------------------------------------------------
  logic [3:0] w_dec_code;
  logic       w_dec_blank;
  logic       w_dec_bad;
  slot_t      w_new_slot;

  seg7_decode u_decode (
    .i_seg   (r_samp.seg),
    .o_code  (w_dec_code),
    .o_blank (w_dec_blank),
    .o_bad   (w_dec_bad)
  );

  assign w_new_slot = {w_dec_code, w_dec_blank, w_dec_bad, r_samp.pt};

  // ---------------------------------------------------------------------------
  // Working slots and seen mask. A full mask is consumed on the following edge
  // by the frame logic; a capture landing on that same edge starts the next
  // frame's mask instead of being lost.
  // ---------------------------------------------------------------------------
  slot_t      r_slot [4];
  logic [3:0] r_seen;
  logic       w_done;

  assign w_done = (r_seen == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_strobe) begin
      for (int i = 0; i < 4; i++) begin
        if (r_samp.act[i]) begin
          r_slot[i] <= w_new_slot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seen <= 4'h0;
    end else if (w_done) begin
      r_seen <= w_strobe ? r_samp.act : 4'h0;
    end else if (w_strobe) begin
      r_seen <= r_seen | r_samp.act;
    end
  end

  // Multi-hot enable: flag once per dwell, at the same point a capture would fire.
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_settle_hit && w_multi;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame hand-off state machine with registered outputs.
  // ---------------------------------------------------------------------------
  frame_state_e r_state;
  logic         r_valid;
  logic         r_overrun;
  logic [15:0]  r_digits;
  logic [3:0]   r_blank;
  logic [3:0]   r_bad;
  logic [3:0]   r_dp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= COLLECT;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_digits  <= '0;
      r_blank   <= '0;
      r_bad     <= '0;
      r_dp      <= '0;
    end else begin
      r_overrun <= 1'b0;

      // Any completed frame is published, whichever state we are in.
      if (w_done) begin
        for (int i = 0; i < 4; i++) begin
          r_digits[4*i +: 4] <= r_slot[i].code;
          r_blank[i]         <= r_slot[i].blank;
          r_bad[i]           <= r_slot[i].bad;
          r_dp[i]            <= r_slot[i].dp;
        end
      end

      case (r_state)
        COLLECT: begin
          if (w_done) begin
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (w_done) begin
            // Accepted on the same edge a new frame lands: a clean hand-over.
            r_overrun <= ~frame_ready;
          end else if (frame_ready) begin
            r_valid <= 1'b0;
            r_state <= COLLECT;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= COLLECT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Staleness: cycles since the last completed frame, saturating.
  // ---------------------------------------------------------------------------
  logic [AGE_W-1:0] r_age;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_age <= '0;
    end else if (w_done) begin
      r_age <= '0;
    end else if (r_age != AGE_MAX) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign frame_valid = r_valid;
  assign digits      = r_digits;
  assign blank       = r_blank;
  assign bad         = r_bad;
  assign dp          = r_dp;
  assign err         = r_err;
  assign overrun     = r_overrun;
  assign stale       = (r_age == AGE_MAX);

endmodule
